// File: rtl/cnna_mul_pipe_if.sv
// Valid/ready bundle for cnna_mul_pipe: master is the upstream/downstream side, slave is the multiplier.
// in_last exists only when CNNA_MUL_PIPE_ACC_EN is defined.
interface cnna_mul_pipe_if #(
    parameter int DIN0_W = 22,
    parameter int DIN1_W = 13,
    parameter int DOUT_W = 35
);
    logic              in_valid;
    logic              in_ready;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              a_sgn;
    logic              b_sgn;
`ifdef CNNA_MUL_PIPE_ACC_EN
    logic              in_last;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] dout;
    logic              sat;

    modport master (
`ifdef CNNA_MUL_PIPE_ACC_EN
        output in_last,
`endif
        output in_valid, din0, din1, a_sgn, b_sgn, out_ready,
        input  in_ready, out_valid, dout, sat
    );

    modport slave (
`ifdef CNNA_MUL_PIPE_ACC_EN
        input  in_last,
`endif
        input  in_valid, din0, din1, a_sgn, b_sgn, out_ready,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/cnna_mul_pipe.sv
// Pipelined signed/unsigned multiplier with arithmetic shift, saturation and valid/ready stall.
// Optional accumulate-until-last mode is enabled by defining CNNA_MUL_PIPE_ACC_EN.
module cnna_mul_pipe #(
    parameter int DIN0_W    = 22,
    parameter int DIN1_W    = 13,
    parameter int DOUT_W    = 35,
    parameter int NUM_STAGE = 2,
    parameter int SHIFT     = 0
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    cnna_mul_pipe_if.slave bus
);
    localparam int P  = DIN0_W + DIN1_W + 2;
    // Working width holds the accumulator sum with headroom and every clip bound.
    localparam int SW = (P + 10 > DOUT_W + 2) ? P + 10 : DOUT_W + 2;
    localparam int D  = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic signed [SW-1:0] S_MAX = (ONE <<< (DOUT_W - 1)) - ONE;
    localparam logic signed [SW-1:0] S_MIN = -(ONE <<< (DOUT_W - 1));
    localparam logic signed [SW-1:0] U_MAX = (ONE <<< DOUT_W) - ONE;

    logic                   adv;
    logic                   in_fire;
    logic                   last_c;
    logic signed [DIN0_W:0] a_ext;
    logic signed [DIN1_W:0] b_ext;
    logic signed [P-1:0]    prod_c;
    logic                   cls_c;

    logic                   f_vld;
    logic                   f_cls;
    logic                   f_last;
    logic signed [P-1:0]    f_prod;

    logic signed [SW-1:0]   shifted;
    logic signed [SW-1:0]   sat_in;
    logic signed [SW-1:0]   clipped;
    logic signed [SW-1:0]   max_v;
    logic signed [SW-1:0]   min_v;
    logic                   clip;
    logic                   ovf_any;
    logic [DOUT_W-1:0]      res_d;
    logic                   sat_d;
    logic                   vld_d;

    logic [DOUT_W-1:0]      dout_q [D];
    logic                   sat_q  [D];
    logic                   vld_q  [D];

    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign in_fire      = bus.in_valid & adv;

    assign a_ext  = {bus.a_sgn & bus.din0[DIN0_W-1], bus.din0};
    assign b_ext  = {bus.b_sgn & bus.din1[DIN1_W-1], bus.din1};
    assign prod_c = $signed(P'(a_ext)) * $signed(P'(b_ext));
    assign cls_c  = bus.a_sgn | bus.b_sgn;

`ifdef CNNA_MUL_PIPE_ACC_EN
    assign last_c = bus.in_last;
`else
    assign last_c = 1'b1;
`endif

    // Product register in front of the shift/saturate logic; absent when the whole job fits one stage.
    generate
        if (NUM_STAGE > 1) begin : g_pre
            logic                vld_q1;
            logic                cls_q1;
            logic                last_q1;
            logic signed [P-1:0] prod_q1;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    vld_q1  <= 1'b0;
                    cls_q1  <= 1'b0;
                    last_q1 <= 1'b0;
                    prod_q1 <= '0;
                end else if (adv) begin
                    // NOTE: non-blocking assignments so every register samples pre-edge values, in any order.
                    vld_q1  <= in_fire;
                    cls_q1  <= cls_c;
                    last_q1 <= last_c;
                    prod_q1 <= prod_c;
                end
            end

            assign f_vld  = vld_q1;
            assign f_cls  = cls_q1;
            assign f_last = last_q1;
            assign f_prod = prod_q1;
        end else begin : g_nopre
            assign f_vld  = in_fire;
            assign f_cls  = cls_c;
            assign f_last = last_c;
            assign f_prod = prod_c;
        end
    endgenerate

`ifdef CNNA_MUL_PIPE_ACC_EN
    localparam int AW = P + 8;
    localparam logic signed [SW-1:0] ACC_MAX = (ONE <<< (AW - 1)) - ONE;
    localparam logic signed [SW-1:0] ACC_MIN = -(ONE <<< (AW - 1));

    logic signed [AW-1:0] acc_q;
    logic                 ovf_q;
    logic signed [SW-1:0] acc_sum;
`endif

    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned and infers a latch.
        shifted = $signed(SW'(f_prod)) >>> SHIFT;
        sat_in  = shifted;
        ovf_any = 1'b0;
`ifdef CNNA_MUL_PIPE_ACC_EN
        // The running sum clamps at the accumulator range and remembers that it did.
        acc_sum = $signed(SW'(acc_q)) + shifted;
        if (acc_sum > ACC_MAX) begin
            sat_in  = ACC_MAX;
            ovf_any = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
            sat_in  = ACC_MIN;
            ovf_any = 1'b1;
        end else begin
            sat_in  = acc_sum;
        end
        ovf_any = ovf_any | ovf_q;
`endif
        max_v   = f_cls ? S_MAX : U_MAX;
        min_v   = f_cls ? S_MIN : '0;
        clipped = sat_in;
        clip    = 1'b0;
        if (sat_in > max_v) begin
            clipped = max_v;
            clip    = 1'b1;
        end else if (sat_in < min_v) begin
            clipped = min_v;
            clip    = 1'b1;
        end
        res_d = DOUT_W'(clipped);
        sat_d = clip | ovf_any;
        vld_d = f_vld & f_last;
    end

`ifdef CNNA_MUL_PIPE_ACC_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv && f_vld) begin
            if (f_last) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= AW'(sat_in);
                ovf_q <= ovf_any;
            end
        end
    end
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: data registers are reset too, so dout reads 0 rather than stale data after reset.
            for (int i = 0; i < D; i++) begin
                dout_q[i] <= '0;
                sat_q[i]  <= 1'b0;
                vld_q[i]  <= 1'b0;
            end
        end else if (adv) begin
            dout_q[0] <= res_d;
            sat_q[0]  <= sat_d;
            vld_q[0]  <= vld_d;
            for (int i = 1; i < D; i++) begin
                dout_q[i] <= dout_q[i-1];
                sat_q[i]  <= sat_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign bus.out_valid = vld_q[D-1];
    assign bus.dout      = dout_q[D-1];
    assign bus.sat       = sat_q[D-1];
endmodule
